// File: rtl/pulse_period_meter_if.sv
// Result port of the pulse period meter: one latched period
// plus its flag, offered on a single-entry valid/ready handshake.
interface pulse_period_meter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             overflow;
    logic             result_ready;

    modport master (
        output period,
        output period_valid,
        output overflow,
        input  result_ready
    );

    modport slave (
        input  period,
        input  period_valid,
        input  overflow,
        output result_ready
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clock cycles between consecutive rising edges of a
// synchronous pulse stream; results leave through a valid/ready port.
module pulse_period_meter #(
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pulse_in,
    pulse_period_meter_if.master  res,
    output logic                  overrun,
    output logic                  busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_pulse_d;
    logic             r_valid;
    logic             r_ovf;
    logic             r_overrun;
    logic             w_edge;
    logic             w_load;
    logic             w_accept;

    assign w_edge   = pulse_in & ~r_pulse_d;
    assign w_load   = enable & (r_state == S_MEASURE) & w_edge;
    assign w_accept = r_valid & res.result_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:    w_next = S_ARMED;
                S_ARMED:   if (w_edge) w_next = S_MEASURE;
                S_MEASURE: w_next = S_MEASURE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // cnt holds the cycles elapsed since the last counted edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pulse_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_pulse_d <= pulse_in;
            if (!enable)
                r_cnt <= '0;
            else if (w_edge && r_state != S_IDLE)
                r_cnt <= CNT_ONE;
            else if (r_state == S_MEASURE && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_period <= r_cnt;
            r_ovf    <= (r_cnt == CNT_MAX);
            r_valid  <= 1'b1;
        end else if (w_accept) begin
            r_valid  <= 1'b0;
        end
    end

    // sticky until disabled: a pending result was replaced unread
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_overrun <= 1'b0;
        else if (!enable)
            r_overrun <= 1'b0;
        else if (w_load && r_valid && !res.result_ready)
            r_overrun <= 1'b1;
    end

    assign res.period       = r_period;
    assign res.period_valid = r_valid;
    assign res.overflow     = r_ovf;
    assign overrun          = r_overrun;
    assign busy             = (r_state != S_IDLE);
endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: an 8-bit and a 4-bit instance share
// one stimulus and are compared every cycle against an edge-time model.
module tb_pulse_period_meter;
    logic clock;
    logic reset;
    logic enable;
    logic pulse_in;
    logic result_ready;
    logic ovr8, busy8, ovr4, busy4;

    pulse_period_meter_if #(.WIDTH(8)) if8 ();
    pulse_period_meter_if #(.WIDTH(4)) if4 ();

    assign if8.result_ready = result_ready;
    assign if4.result_ready = result_ready;

    pulse_period_meter #(.WIDTH(8)) dut8 (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .pulse_in (pulse_in),
        .res      (if8),
        .overrun  (ovr8),
        .busy     (busy8)
    );

    pulse_period_meter #(.WIDTH(4)) dut4 (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .pulse_in (pulse_in),
        .res      (if4),
        .overrun  (ovr4),
        .busy     (busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // model: time of last counted edge, and the latched result
    int t = 0;
    int m_t0 = 0;
    bit m_active = 0;
    bit m_ref = 0;
    bit m_prev = 0;
    bit m_valid = 0;
    bit m_overrun = 0;
    int m_per8 = 0, m_per4 = 0;
    bit m_ovf8 = 0, m_ovf4 = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h",
                   tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("period8", 32'(if8.period), 32'(m_per8));
        chk("valid8", 32'(if8.period_valid), 32'(m_valid));
        chk("ovf8", 32'(if8.overflow), 32'(m_ovf8));
        chk("overrun8", 32'(ovr8), 32'(m_overrun));
        chk("busy8", 32'(busy8), 32'(m_active));
        chk("period4", 32'(if4.period), 32'(m_per4));
        chk("valid4", 32'(if4.period_valid), 32'(m_valid));
        chk("ovf4", 32'(if4.overflow), 32'(m_ovf4));
        chk("overrun4", 32'(ovr4), 32'(m_overrun));
        chk("busy4", 32'(busy4), 32'(m_active));
    endtask

    task automatic model_reset();
        m_active = 0; m_ref = 0; m_prev = 0;
        m_valid = 0; m_overrun = 0;
        m_per8 = 0; m_per4 = 0; m_ovf8 = 0; m_ovf4 = 0;
    endtask

    task automatic model_step(input bit pin, input bit en, input bit rdy);
        bit edge_s, acc, newr;
        int d;
        edge_s = pin && !m_prev;
        m_prev = pin;
        acc = m_valid && rdy;
        newr = 0;
        d = 0;
        if (!en) begin
            m_active = 0; m_ref = 0; m_overrun = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (edge_s) begin
            if (m_ref) begin
                newr = 1;
                d = t - m_t0;
            end
            m_ref = 1;
            m_t0 = t;
        end
        if (newr) begin
            if (m_valid && !rdy) m_overrun = 1;
            m_per8 = (d > 255) ? 255 : d;
            m_ovf8 = (d >= 255);
            m_per4 = (d > 15) ? 15 : d;
            m_ovf4 = (d >= 15);
            m_valid = 1;
        end else if (acc) begin
            m_valid = 0;
        end
    endtask

    task automatic cyc(input bit pin, input bit en, input bit rdy);
        pulse_in = pin; enable = en; result_ready = rdy;
        @(posedge clock);
        model_step(pin, en, rdy);
        t++;
        #1;
        check_all();
    endtask

    task automatic gap(input int len, input int hi, input bit en,
                       input bit rdy);
        for (int k = 0; k < len; k++) cyc(k < hi, en, rdy);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; pulse_in = 1'b0; result_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b1;

        // 5-cycle stream, consumer always ready
        cyc(0, 1, 1);
        repeat (5) gap(5, 1, 1, 1);
        // saturation on the 4-bit instance, then a normal period
        gap(20, 1, 1, 1);
        gap(6, 1, 1, 1);
        gap(6, 1, 1, 1);
        // consumer stalls: periods 6 then 9 overwrite, then one accept
        gap(6, 1, 1, 0);
        gap(9, 1, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 1, 1);
        gap(5, 0, 1, 0);
        // long high pulse counts as one edge
        gap(7, 3, 1, 1);
        gap(7, 3, 1, 1);
        gap(4, 1, 1, 1);
        // disable mid-measure, re-enable, re-arm
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        gap(4, 1, 1, 1);
        gap(4, 1, 1, 1);
        gap(4, 1, 1, 1);
        // async reset with a result pending mid-measure
        gap(6, 1, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;

        // randomized bursts
        for (int b = 0; b < 60; b++) begin
            int len, hi;
            bit en;
            len = $urandom_range(2, 24);
            hi = $urandom_range(1, len - 1);
            en = ($urandom_range(0, 15) != 0);
            for (int k = 0; k < len; k++)
                cyc(k < hi, en, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
